// File: rtl/ook_pkg.sv
// Shared types and constants for the OOK transmit sequencer.
package ook_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        DATA  = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam logic [7:0] DA_MID       = 8'h80;
    localparam logic [7:0] PREAMBLE_DEF = 8'hAA;

endpackage

// File: rtl/ook_frame_ctrl_if.sv
// Byte input, carrier input and DAC/status outputs of the OOK frame controller.
interface ook_frame_ctrl_if;

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic signed [7:0] carrier;
    logic [7:0]        dadata;
    logic              sym_bit;
    logic              busy;
    logic              fifo_full;
    logic              overflow;
    logic              frame_done;

    modport master (
        output rx_valid, rx_data, carrier,
        input  dadata, sym_bit, busy, fifo_full, overflow, frame_done
    );

    modport slave (
        input  rx_valid, rx_data, carrier,
        output dadata, sym_bit, busy, fifo_full, overflow, frame_done
    );

endinterface

// File: rtl/ook_byte_fifo.sv
// Single-clock show-ahead byte FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module ook_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          push_ok, pop_ok;

    assign pop_ok  = pop_i && !empty_q;
    assign push_ok = push_i && (!full_q || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/ook_frame_ctrl.sv
// OOK transmit sequencer: buffers UART bytes, frames each as preamble/data/guard
// at SYM_DIV clocks per symbol and gates the DDS carrier into the DAC stream.
module ook_frame_ctrl
    import ook_pkg::*;
#(
    parameter int         SYM_DIV    = 2500,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] PREAMBLE   = PREAMBLE_DEF,
    parameter int         GUARD_SYMS = 2
) (
    input logic             clk,
    input logic             reset,
    ook_frame_ctrl_if.slave bus
);

    localparam logic [15:0] SYM_LAST   = 16'(SYM_DIV - 1);
    localparam logic [3:0]  GUARD_LAST = 4'(GUARD_SYMS - 1);

    state_t      state_q, state_d;
    logic [15:0] sym_cnt_q, sym_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  preg_q, preg_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  dadata_q;
    logic        busy_q, frame_done_q, frame_done_d, overflow_q, overflow_d;
    logic        sym_tick, sym_bit, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;

    // Offset-binary conversion of the two's-complement carrier: an MSB flip.
    function automatic logic [7:0] mod_sample(input logic on, input logic signed [7:0] s);
        return on ? {~s[7], s[6:0]} : DA_MID;
    endfunction

    ook_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.rx_valid),
        .pop_i   (fifo_pop),
        .din_i   (bus.rx_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign sym_tick   = (state_q != IDLE) && (sym_cnt_q == SYM_LAST);
    assign overflow_d = overflow_q | (bus.rx_valid && fifo_full && !fifo_pop);

    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        preg_d       = preg_q;
        shreg_d      = shreg_q;
        frame_done_d = 1'b0;
        fifo_pop     = 1'b0;
        sym_bit      = 1'b0;
        if (state_q != IDLE) begin
            sym_cnt_d = sym_tick ? 16'd0 : sym_cnt_q + 16'd1;
        end
        case (state_q)
            IDLE: begin
                sym_cnt_d = 16'd0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = fifo_dout;
                    preg_d    = PREAMBLE;
                    bit_cnt_d = 4'd7;
                    state_d   = PRE;
                end
            end
            PRE: begin
                sym_bit = preg_q[7];
                if (sym_tick) begin
                    preg_d = {preg_q[6:0], 1'b0};
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd7;
                        state_d   = DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
            end
            DATA: begin
                sym_bit = shreg_q[7];
                if (sym_tick) begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = GUARD_LAST;
                        state_d   = GUARD;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
            end
            GUARD: begin
                if (sym_tick) begin
                    if (bit_cnt_q == 4'd0) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sym_cnt_q    <= 16'd0;
            bit_cnt_q    <= 4'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            dadata_q     <= DA_MID;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            busy_q       <= (state_d != IDLE);
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            dadata_q     <= mod_sample(sym_bit, bus.carrier);
        end
    end

    // Shift registers only matter outside IDLE, where they were just loaded.
    always_ff @(posedge clk) begin
        preg_q  <= preg_d;
        shreg_q <= shreg_d;
    end

    assign bus.dadata     = dadata_q;
    assign bus.sym_bit    = sym_bit;
    assign bus.busy       = busy_q;
    assign bus.fifo_full  = fifo_full;
    assign bus.overflow   = overflow_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ook_frame_ctrl.sv
// Directed bench for ook_frame_ctrl with SYM_DIV=4, GUARD_SYMS=2, carrier fixed at 8'h40.
module tb_ook_frame_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    ook_frame_ctrl_if bus ();

    ook_frame_ctrl #(
        .SYM_DIV    (4),
        .FIFO_DEPTH (16),
        .PREAMBLE   (8'hAA),
        .GUARD_SYMS (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge right after the IDLE->PRE pop cycle began (cycle 0);
    // returns at cycle 73, where frame_done of this frame is expected.
    task automatic check_frame(input logic [7:0] b, input logic fd0, input logic push_en,
                               input logic [7:0] push_b, input logic chk_full);
        logic [17:0] pat;
        logic        exp_bit, prev_bit;
        pat      = {8'hAA, b, 2'b00};
        prev_bit = 1'b0;
        for (int j = 0; j < 73; j++) begin
            exp_bit = (j == 0) ? 1'b0 : pat[17 - (j - 1) / 4];
            chk("sym_bit", {7'd0, bus.sym_bit}, {7'd0, exp_bit});
            chk("busy", {7'd0, bus.busy}, {7'd0, (j != 0)});
            chk("dadata", bus.dadata, prev_bit ? 8'hC0 : 8'h80);
            chk("frame_done", {7'd0, bus.frame_done}, {7'd0, (j == 0) ? fd0 : 1'b0});
            if (j == 1 && chk_full) begin
                chk("full_after_pushpop", {7'd0, bus.fifo_full}, 8'd1);
                chk("ovf_after_pushpop", {7'd0, bus.overflow}, 8'd0);
            end
            prev_bit     = exp_bit;
            bus.rx_valid = (j == 0) && push_en;
            bus.rx_data  = push_b;
            @(negedge clk);
        end
    endtask

    task automatic wait_fd(input int maxc);
        int n;
        n = 0;
        while (bus.frame_done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_wait", {7'd0, bus.frame_done}, 8'd1);
    endtask

    task automatic push_burst(input int cnt, input logic [7:0] base);
        for (int i = 0; i < cnt; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = base + 8'(i);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.carrier  = 8'sh40;
        repeat (2) @(negedge clk);
        chk("rst_dadata", bus.dadata, 8'h80);
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("rst_sym_bit", {7'd0, bus.sym_bit}, 8'd0);
        chk("rst_full", {7'd0, bus.fifo_full}, 8'd0);
        chk("rst_ovf", {7'd0, bus.overflow}, 8'd0);
        chk("rst_fd", {7'd0, bus.frame_done}, 8'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_dadata", bus.dadata, 8'h80);
        chk("rel_busy", {7'd0, bus.busy}, 8'd0);
        chk("rel_ovf", {7'd0, bus.overflow}, 8'd0);
        for (int i = 0; i < 200; i++) begin
            chk("idle_dadata", bus.dadata, 8'h80);
            chk("idle_busy", {7'd0, bus.busy}, 8'd0);
            @(negedge clk);
        end

        // Single byte C3
        push_one(8'hC3);
        check_frame(8'hC3, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("single_fd", {7'd0, bus.frame_done}, 8'd1);
        chk("single_end_busy", {7'd0, bus.busy}, 8'd0);
        @(negedge clk);
        chk("single_fd_once", {7'd0, bus.frame_done}, 8'd0);
        chk("single_idle_busy", {7'd0, bus.busy}, 8'd0);

        // Back-to-back 01 then FF
        push_one(8'h01);
        check_frame(8'h01, 1'b0, 1'b1, 8'hFF, 1'b0);
        check_frame(8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("b2b_fd", {7'd0, bus.frame_done}, 8'd1);
        @(negedge clk);
        chk("b2b_idle_busy", {7'd0, bus.busy}, 8'd0);

        // Push in the same cycle as the IDLE pop with 16 bytes buffered
        push_one(8'hA0);
        @(negedge clk);
        push_burst(16, 8'h10);
        chk("pp_full", {7'd0, bus.fifo_full}, 8'd1);
        chk("pp_ovf", {7'd0, bus.overflow}, 8'd0);
        wait_fd(200);
        check_frame(8'h10, 1'b1, 1'b1, 8'h5C, 1'b1);
        for (int i = 1; i < 16; i++) check_frame(8'h10 + 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
        check_frame(8'h5C, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("pp_fd", {7'd0, bus.frame_done}, 8'd1);
        @(negedge clk);
        chk("pp_idle_busy", {7'd0, bus.busy}, 8'd0);
        chk("pp_empty_full", {7'd0, bus.fifo_full}, 8'd0);
        chk("pp_ovf_end", {7'd0, bus.overflow}, 8'd0);

        // Overflow: 17 pushes while a frame is running
        push_one(8'hB0);
        @(negedge clk);
        push_burst(17, 8'h20);
        chk("ovf_full", {7'd0, bus.fifo_full}, 8'd1);
        chk("ovf_flag", {7'd0, bus.overflow}, 8'd1);
        wait_fd(200);
        for (int i = 0; i < 16; i++) check_frame(8'h20 + 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
        chk("ovf_last_fd", {7'd0, bus.frame_done}, 8'd1);
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            chk("ovf_no17_busy", {7'd0, bus.busy}, 8'd0);
            chk("ovf_no17_sym", {7'd0, bus.sym_bit}, 8'd0);
            @(negedge clk);
        end
        chk("ovf_sticky", {7'd0, bus.overflow}, 8'd1);

        // Mid-frame reset during DATA, with bytes still buffered
        push_one(8'h5A);
        for (int k = 0; k < 40; k++) begin
            bus.rx_valid = (k < 2);
            bus.rx_data  = (k == 0) ? 8'h11 : 8'h22;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        chk("mid_busy", {7'd0, bus.busy}, 8'd1);
        chk("mid_dadata", bus.dadata, 8'hC0);
        reset = 1'b0;
        #1;
        chk("arst_dadata", bus.dadata, 8'h80);
        chk("arst_busy", {7'd0, bus.busy}, 8'd0);
        chk("arst_sym_bit", {7'd0, bus.sym_bit}, 8'd0);
        chk("arst_ovf", {7'd0, bus.overflow}, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            chk("post_rst_busy", {7'd0, bus.busy}, 8'd0);
            chk("post_rst_dadata", bus.dadata, 8'h80);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
